lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
//  Load/store unit that consumes the control decoder's memory controls (MemRw, LoadStoreMode) and executes the access.
//  Drives a word-wide data-memory bus with a req/ready handshake and stalls the core until the access completes.
//  Performs byte-lane steering, store strobes, load sign/zero extension, misalignment detection and bus timeout.
//  Sits between the EX stage (address from ALU) and data memory; its result feeds the WB mux.
// PARAMETERS
//  TIMEOUT   16  max cycles bus_req may wait for bus_ready before the access aborts with a fault (>=1)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst_n          in   1   synchronous active-low reset
//  mem_valid      in   1   core presents a load/store this cycle (held stable while stall=1)
//  MemRw          in   1   1=store, 0=load
//  LoadStoreMode  in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr           in   32  byte address
//  wdata          in   32  store data (rs2)
//  stall          out  1   freeze PC/pipeline
//  done           out  1   one-cycle pulse: access finished (OK or fault)
//  fault          out  1   with done: misaligned, illegal mode, or timeout
//  rdata          out  32  extended load result, valid when done=1 and load
//  bus_req        out  1   bus request
//  bus_we         out  1   bus write enable
//  bus_addr       out  32  word address ({addr[31:2],2'b00})
//  bus_wstrb      out  4   byte strobes (store); 4'b0000 on loads
//  bus_wdata      out  32  lane-steered store data
//  bus_ready      in   1   bus accepts/completes the request this cycle
//  bus_rdata      in   32  read word, valid with bus_ready on loads
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; bus_req, bus_we, done, fault=0; bus_wstrb=0; rdata, bus_addr, bus_wdata=0; timer=0.
//  FSM states: IDLE, BUS, DONE, FAULT.
//   IDLE: mem_valid=1 -> latch addr/mode/MemRw/wdata; go BUS if legal, else FAULT. mem_valid=0 -> stay.
//   BUS: bus_req=1, bus_we=latched MemRw. On bus_req&bus_ready: capture/extend bus_rdata, go DONE.
//        timer increments each BUS cycle without ready; timer reaches TIMEOUT -> FAULT, bus_req drops.
//   DONE: done=1, fault=0, stall=0, then IDLE. FAULT: done=1, fault=1, stall=0, then IDLE.
//  stall = (IDLE & mem_valid) | BUS, computed combinationally. Stall is 0 in DONE/FAULT, so the core advances.
//  mem_valid is ignored in BUS/DONE/FAULT. The next access is sampled in IDLE, so back-to-back accesses cost one idle cycle minimum.
//  Latency: an aligned access with bus_ready in its first BUS cycle gives done 2 cycles after mem_valid is sampled.
//  Legality:
//   H/HU requires addr[0]=0. W requires addr[1:0]=0.
//   Modes 011/110/111 are illegal. Store with mode 1xx is illegal.
//   Faulting accesses never assert bus_req.
//  Store lanes:
//   B: wstrb=4'b0001<<addr[1:0], wdata byte replicated x4.
//   H: wstrb=4'b0011<<addr[1:0], half replicated x2.
//   W: wstrb=4'b1111.
//  Load: select byte/half at addr[1:0]. Sign-extend for 000/001, zero-extend for 100/101. W passes through.
//  rdata holds its last value until the next completed load. It is not cleared by stores or faults.
//  bus_addr/bus_wdata/bus_wstrb are stable for the whole BUS phase.
//  bus_ready outside BUS is ignored.
//  Reset mid-BUS: bus_req=0 at that edge. A late bus_ready/bus_rdata is ignored, and no done pulse is produced.
//  Simultaneous bus_ready and timer==TIMEOUT-1: ready wins (DONE).
// TESTING
//  LW: addr 0x1000, bus_ready after 3 BUS cycles, bus_rdata 0xDEADBEEF
//      -> stall 4 cycles; done; rdata=0xDEADBEEF; wstrb=0.
//  LB: addr 0x1003, bus_rdata 0x80123456 -> rdata=0xFFFFFF80.
//      LBU same -> 0x00000080. LHU addr 0x1002 -> 0x00008012.
//  SB: addr 0x2001, wdata 0x000000AB -> bus_we=1, wstrb=4'b0010, bus_wdata=0xABABABAB, bus_addr=0x2000.
//      SH addr 0x2002 -> wstrb=4'b1100.
//  Misaligned: LW addr 0x1002, then SW mode 110 -> each gives done=1, fault=1 one cycle later; bus_req never 1.
//  Timeout: TIMEOUT=4, bus_ready held 0 -> bus_req high 4 cycles, then fault pulse; stall released.
//  Reset: rst_n=0 in 2nd BUS cycle, then bus_ready=1 next cycle -> bus_req=0, no done, state IDLE, outputs at reset values.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
//   bus_req   : LSU requests an access (held for the whole bus phase)
//   bus_we    : 1 = write, 0 = read
//   bus_addr  : word-aligned byte address
//   bus_wstrb : byte strobes for writes, zero for reads
//   bus_wdata : lane-steered write data
//   bus_ready : memory accepts/completes the request this cycle
//   bus_rdata : read word, valid with bus_ready on reads
interface lsu_mem_ctrl_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: executes one memory access per core request over a
// req/ready data bus, stalling the core until it completes or faults.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   mem_valid      : core presents a load/store (held while stall=1)
//   MemRw          : 1 = store, 0 = load
//   LoadStoreMode  : funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr, wdata    : byte address and store data from the core
//   stall          : combinational pipeline freeze
//   done, fault    : one-cycle completion pulse and its fault flag
//   rdata          : extended load result, held until the next completed load
//   bus            : data-memory bus (master side)
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_valid,
   input  logic                 MemRw,
   input  logic [2:0]           LoadStoreMode,
   input  logic [31:0]          addr,
   input  logic [31:0]          wdata,
   output logic                 stall,
   output logic                 done,
   output logic                 fault,
   output logic [31:0]          rdata,
   lsu_mem_ctrl_if.master       bus
);

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUS   = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    mode_q, mode_d;
   logic [1:0]    off_q, off_d;
   logic          we_q, we_d;

   logic          req_d, bus_we_d, done_d, fault_d;
   logic [31:0]   bus_addr_d, bus_wdata_d, rdata_d;
   logic [3:0]    bus_wstrb_d;

   logic          legal_c;
   logic [3:0]    strb_c;
   logic [31:0]   steer_c;
   logic [31:0]   shifted_c;
   logic [31:0]   ext_c;

   assign stall = ((state_q == IDLE) && mem_valid) || (state_q == BUS);

   // Legality and store lane steering of the incoming request
   always_comb begin
      legal_c = 1'b0;
      case (LoadStoreMode)
         3'b000, 3'b100: legal_c = 1'b1;
         3'b001, 3'b101: legal_c = ~addr[0];
         3'b010:         legal_c = (addr[1:0] == 2'b00);
         default:        legal_c = 1'b0;
      endcase
      // Unsigned variants exist only for loads
      if (MemRw && LoadStoreMode[2]) begin
         legal_c = 1'b0;
      end

      strb_c  = 4'b1111;
      steer_c = wdata;
      case (LoadStoreMode[1:0])
         2'b00: begin
            strb_c  = 4'b0001 << addr[1:0];
            steer_c = {4{wdata[7:0]}};
         end
         2'b01: begin
            strb_c  = 4'b0011 << addr[1:0];
            steer_c = {2{wdata[15:0]}};
         end
         default: begin
            strb_c  = 4'b1111;
            steer_c = wdata;
         end
      endcase
   end

   // Load lane selection and sign/zero extension of the returned word
   always_comb begin
      shifted_c = bus.bus_rdata >> {off_q, 3'b000};
      case (mode_q)
         3'b000:  ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
         3'b001:  ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
         3'b100:  ext_c = {24'h000000, shifted_c[7:0]};
         3'b101:  ext_c = {16'h0000, shifted_c[15:0]};
         default: ext_c = bus.bus_rdata;
      endcase
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      mode_d      = mode_q;
      off_d       = off_q;
      we_d        = we_q;
      req_d       = 1'b0;
      bus_we_d    = 1'b0;
      done_d      = 1'b0;
      fault_d     = 1'b0;
      bus_addr_d  = bus.bus_addr;
      bus_wstrb_d = bus.bus_wstrb;
      bus_wdata_d = bus.bus_wdata;
      rdata_d     = rdata;

      case (state_q)
         IDLE: begin
            if (mem_valid) begin
               mode_d  = LoadStoreMode;
               off_d   = addr[1:0];
               we_d    = MemRw;
               timer_d = '0;
               if (legal_c) begin
                  state_d     = BUS;
                  req_d       = 1'b1;
                  bus_we_d    = MemRw;
                  bus_addr_d  = {addr[31:2], 2'b00};
                  bus_wstrb_d = MemRw ? strb_c : 4'b0000;
                  bus_wdata_d = steer_c;
               end else begin
                  // Faulting accesses never touch the bus
                  state_d = FAULT;
                  done_d  = 1'b1;
                  fault_d = 1'b1;
               end
            end
         end
         BUS: begin
            // Ready takes priority over an expiring timer
            if (bus.bus_ready) begin
               state_d = DONE;
               done_d  = 1'b1;
               if (!we_q) begin
                  rdata_d = ext_c;
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d = FAULT;
               done_d  = 1'b1;
               fault_d = 1'b1;
            end else begin
               timer_d  = TW'(timer_q + 1'b1);
               req_d    = 1'b1;
               bus_we_d = we_q;
            end
         end
         DONE:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         mode_q        <= 3'b000;
         off_q         <= 2'b00;
         we_q          <= 1'b0;
         done          <= 1'b0;
         fault         <= 1'b0;
         rdata         <= 32'h0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= 32'h0;
         bus.bus_wstrb <= 4'b0000;
         bus.bus_wdata <= 32'h0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         mode_q        <= mode_d;
         off_q         <= off_d;
         we_q          <= we_d;
         done          <= done_d;
         fault         <= fault_d;
         rdata         <= rdata_d;
         bus.bus_req   <= req_d;
         bus.bus_we    <= bus_we_d;
         bus.bus_addr  <= bus_addr_d;
         bus.bus_wstrb <= bus_wstrb_d;
         bus.bus_wdata <= bus_wdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: random and directed accesses checked against a
// behavioural model through a scoreboard queue.
module tb_lsu_mem_ctrl;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid;
   logic        MemRw;
   logic [2:0]  LoadStoreMode;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic        fault;
   logic [31:0] rdata;

   lsu_mem_ctrl_if bus ();

   lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_valid     (mem_valid),
      .MemRw         (MemRw),
      .LoadStoreMode (LoadStoreMode),
      .addr          (addr),
      .wdata         (wdata),
      .stall         (stall),
      .done          (done),
      .fault         (fault),
      .rdata         (rdata),
      .bus           (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          imm_fault;
      bit          fault;
      logic [31:0] rdata;
      int          stall;
      bit          we;
      logic [31:0] baddr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_rdata = 32'h0;

   int          lat_cur = 0;
   logic [31:0] rd_cur = 32'h0;
   bit          force_ready = 1'b0;
   int          bus_cnt = 0;
   int          stall_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: derive the expected outcome from size/sign rules
   task automatic push_expect(input bit we, input logic [2:0] mode, input logic [31:0] a,
                              input logic [31:0] wd, input int lat, input logic [31:0] rd);
      exp_t        e;
      int          size;
      bit          sgn;
      bit          bad;
      logic [31:0] v;
      bad  = 1'b0;
      sgn  = 1'b0;
      size = 1;
      case (mode)
         3'd0: begin size = 1; sgn = 1'b1; end
         3'd1: begin size = 2; sgn = 1'b1; end
         3'd2: begin size = 4; end
         3'd4: begin size = 1; end
         3'd5: begin size = 2; end
         default: bad = 1'b1;
      endcase
      if (we && mode >= 3'd4) bad = 1'b1;
      if ((a % size) != 0) bad = 1'b1;
      e.imm_fault = bad;
      e.fault     = bad || (lat >= int'(TO));
      if (bad)                 e.stall = 1;
      else if (lat < int'(TO)) e.stall = lat + 2;
      else                     e.stall = 1 + int'(TO);
      e.we    = we;
      e.baddr = a & 32'hFFFF_FFFC;
      e.wstrb = we ? 4'(((1 << size) - 1) << (a % 4)) : 4'b0000;
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      if (!e.fault && !we) begin
         v = rd >> (8 * (a % 4));
         if (size == 1) begin
            v = v & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
         end else if (size == 2) begin
            v = v & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
         end
         last_rdata = v;
      end
      e.rdata = last_rdata;
      sb_q.push_back(e);
   endtask

   // Issue one access and hold it until the core is released
   task automatic do_access(input bit we, input logic [2:0] mode, input logic [31:0] a,
                            input logic [31:0] wd, input int lat, input logic [31:0] rd);
      bit ok;
      push_expect(we, mode, a, wd, lat, rd);
      lat_cur       = lat;
      rd_cur        = rd;
      mem_valid     = 1'b1;
      MemRw         = we;
      LoadStoreMode = mode;
      addr          = a;
      wdata         = wd;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1;
         if (!stall) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL access_wait: stall never released for addr %h", a);
      end
      mem_valid = 1'b0;
   endtask

   // Memory responder: ready after lat_cur waiting cycles, random noise when idle
   always @(negedge clk) begin
      if (force_ready) begin
         bus.bus_ready = 1'b1;
         bus.bus_rdata = $urandom;
      end else if (bus.bus_req) begin
         bus.bus_ready = (bus_cnt == lat_cur);
         bus.bus_rdata = (bus_cnt == lat_cur) ? rd_cur : $urandom;
         bus_cnt++;
      end else begin
         bus_cnt = 0;
         bus.bus_ready = 1'($urandom_range(0, 1));
         bus.bus_rdata = $urandom;
      end
   end

   // Monitor: bus phase contents and completion results against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         stall_cnt = 0;
      end else begin
         if (stall) stall_cnt++;
         if (bus.bus_req) begin
            if (sb_q.size() == 0 || sb_q[0].imm_fault) begin
               n_checks++;
               n_errors++;
               $display("FAIL bus_req_unexpected: got 1 expected 0 (t=%0t)", $time);
            end else begin
               chk("bus_addr", bus.bus_addr, sb_q[0].baddr);
               chk("bus_we", 32'(bus.bus_we), 32'(sb_q[0].we));
               chk("bus_wstrb", 32'(bus.bus_wstrb), 32'(sb_q[0].wstrb));
               if (sb_q[0].we) chk("bus_wdata", bus.bus_wdata, sb_q[0].wdata);
            end
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL done_unexpected: got 1 expected 0 (t=%0t)", $time);
            end else begin
               e = sb_q.pop_front();
               chk("fault", 32'(fault), 32'(e.fault));
               chk("rdata", rdata, e.rdata);
               chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            end
            stall_cnt = 0;
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      mem_valid     = 1'b0;
      MemRw         = 1'b0;
      LoadStoreMode = 3'b000;
      addr          = 32'h0;
      wdata         = 32'h0;
      bus.bus_ready = 1'b0;
      bus.bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_bus_req", 32'(bus.bus_req), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_fault", 32'(fault), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_bus_wstrb", 32'(bus.bus_wstrb), 32'h0);
      chk("rst_bus_addr", bus.bus_addr, 32'h0);
      chk("rst_stall", 32'(stall), 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases
      do_access(1'b0, 3'b010, 32'h0000_1000, 32'h0, 2, 32'hDEAD_BEEF);
      do_access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h8012_3456);
      do_access(1'b0, 3'b100, 32'h0000_1003, 32'h0, 0, 32'h8012_3456);
      do_access(1'b0, 3'b101, 32'h0000_1002, 32'h0, 1, 32'h8012_3456);
      do_access(1'b1, 3'b000, 32'h0000_2001, 32'h0000_00AB, 0, 32'h0);
      do_access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 0, 32'h0);
      do_access(1'b1, 3'b010, 32'h0000_2004, 32'hCAFE_F00D, 3, 32'h0);
      do_access(1'b0, 3'b010, 32'h0000_1002, 32'h0, 0, 32'h1111_1111);
      do_access(1'b1, 3'b110, 32'h0000_1000, 32'h0, 0, 32'h0);
      do_access(1'b0, 3'b001, 32'h0000_1001, 32'h0, 0, 32'h0);
      do_access(1'b1, 3'b100, 32'h0000_1000, 32'h0, 0, 32'h0);
      do_access(1'b0, 3'b010, 32'h0000_1000, 32'h0, 99, 32'h0);
      do_access(1'b0, 3'b001, 32'h0000_1000, 32'h0, int'(TO) - 1, 32'h0000_F00F);

      // Random accesses with random idle gaps (zero gap is back-to-back)
      for (int n = 0; n < 250; n++) begin
         do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, int'($urandom_range(0, 5)), $urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
      end

      // Reset in the second bus cycle, then a late ready
      @(posedge clk);
      #1;
      push_expect(1'b0, 3'b010, 32'h0000_3000, 32'h0, 99, 32'h0);
      lat_cur       = 99;
      mem_valid     = 1'b1;
      MemRw         = 1'b0;
      LoadStoreMode = 3'b010;
      addr          = 32'h0000_3000;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("bus2_req", 32'(bus.bus_req), 32'h1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      mem_valid   = 1'b0;
      force_ready = 1'b1;
      void'(sb_q.pop_front());
      last_rdata  = 32'h0;
      chk("rst_mid_bus_req", 32'(bus.bus_req), 32'h0);
      @(posedge clk);
      #1;
      force_ready = 1'b0;
      chk("rst_mid_done", 32'(done), 32'h0);
      chk("rst_mid_stall", 32'(stall), 32'h0);
      chk("rst_mid_rdata", rdata, 32'h0);
      chk("rst_mid_bus_addr", bus.bus_addr, 32'h0);
      chk("rst_mid_bus_wdata", bus.bus_wdata, 32'h0);
      chk("rst_mid_bus_wstrb", 32'(bus.bus_wstrb), 32'h0);
      @(posedge clk);
      #1;
      do_access(1'b0, 3'b001, 32'h0000_4002, 32'h0, 1, 32'h9ABC_1234);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
